// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM state encodings and default width.
`ifndef SERIAL_ADDER_PKG_SV
`define SERIAL_ADDER_PKG_SV

package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

`endif

// File: rtl/fullAdder.sv
// Single-bit full adder composed of two half adders; the only arithmetic cell in serial_adder.
module fullAdder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic sum_o,
    output logic c_o
);

    logic ha0_sum;
    logic ha0_c;
    logic ha1_c;

    halfAdder u_ha0 (
        .a_i   (a_i),
        .b_i   (b_i),
        .sum_o (ha0_sum),
        .c_o   (ha0_c)
    );

    halfAdder u_ha1 (
        .a_i   (ha0_sum),
        .b_i   (c_i),
        .sum_o (sum_o),
        .c_o   (ha1_c)
    );

    assign c_o = ha0_c | ha1_c;

endmodule

// File: rtl/halfAdder.sv
// Single-bit half adder built from gates; the leaf cell of the serial datapath.
module halfAdder (
    input  logic a_i,
    input  logic b_i,
    output logic sum_o,
    output logic c_o
);

    assign sum_o = a_i ^ b_i;
    assign c_o   = a_i & b_i;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder/subtractor: one full-adder step per cycle, LSB first, with
// ready/valid handshakes on both sides and carry/overflow/zero/negative status flags.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] result,
    output logic             cOut,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] op_a_q;
    logic [WIDTH-1:0] op_b_q;
    logic [WIDTH-1:0] result_q;
    logic [CW-1:0]    count_q;
    logic             carry_q;
    logic             cout_q;
    logic             ovf_q;
    logic             zero_q;
    logic             neg_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH-1:0] result_d;

    fullAdder u_fa (
        .a_i   (op_a_q[0]),
        .b_i   (op_b_q[0]),
        .c_i   (carry_q),
        .sum_o (fa_sum),
        .c_o   (fa_cout)
    );

    // Sum bits enter at the MSB so after WIDTH steps bit 0 of the answer lands in result[0].
    assign result_d = {fa_sum, result_q[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q     <= IDLE;
            op_a_q      <= '0;
            op_b_q      <= '0;
            result_q    <= '0;
            count_q     <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (inValid) begin
                        // Subtraction is a + ~b + 1: invert b here, inject the +1 as carry-in.
                        op_a_q     <= a;
                        op_b_q     <= b ^ {WIDTH{sub}};
                        carry_q    <= sub;
                        count_q    <= '0;
                        state_q    <= RUN;
                        in_ready_q <= 1'b0;
                    end
                end
                RUN: begin
                    result_q <= result_d;
                    op_a_q   <= op_a_q >> 1;
                    op_b_q   <= op_b_q >> 1;
                    carry_q  <= fa_cout;
                    count_q  <= count_q + 1'b1;
                    if (count_q == LAST) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        cout_q      <= fa_cout;
                        ovf_q       <= carry_q ^ fa_cout;
                        zero_q      <= (result_d == '0);
                        neg_q       <= fa_sum;
                    end
                end
                DONE: begin
                    if (outReady) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign inReady  = in_ready_q;
    assign outValid = out_valid_q;
    assign result   = result_q;
    assign cOut     = cout_q;
    assign overflow = ovf_q;
    assign zero     = zero_q;
    assign negative = neg_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=32): directed vector table, reset/backpressure
// sequences and randomized back-to-back operations against an arithmetic reference model.
module tb_serial_adder;

    localparam int W      = 32;
    localparam int N_RAND = 1000;

    logic          clk;
    logic          rstN;
    logic          inValid;
    logic          inReady;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          sub;
    logic          outValid;
    logic          outReady;
    logic [W-1:0]  result;
    logic          cOut;
    logic          overflow;
    logic          zero;
    logic          negative;

    int checks;
    int passes;
    int fails;
    int cyc;
    int accept_cyc;

    typedef struct {
        logic          s;
        logic [W-1:0]  x;
        logic [W-1:0]  y;
        logic [W+3:0]  exp;
    } vec_t;

    vec_t vecs[8];

    serial_adder #(.WIDTH(W)) dut (
        .clk      (clk),
        .rstN     (rstN),
        .inValid  (inValid),
        .inReady  (inReady),
        .a        (a),
        .b        (b),
        .sub      (sub),
        .outValid (outValid),
        .outReady (outReady),
        .result   (result),
        .cOut     (cOut),
        .overflow (overflow),
        .zero     (zero),
        .negative (negative)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain two's-complement arithmetic; packed as {result, cOut, overflow, zero, negative}.
    function automatic logic [W+3:0] model(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0]   wide;
        logic [W-1:0] r;
        logic         c;
        logic         v;
        if (!s) begin
            wide = {1'b0, x} + {1'b0, y};
            r    = wide[W-1:0];
            c    = wide[W];
            v    = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
        end else begin
            r = x - y;
            c = (x >= y);
            v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
        end
        return {r, c, v, (r == '0), r[W-1]};
    endfunction

    function automatic logic [W+3:0] dut_out();
        return {result, cOut, overflow, zero, negative};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            passes++;
        end
    endtask

    // Called at a negedge; returns at the negedge following the acceptance edge.
    task automatic start_op(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
        int n;
        inValid = 1'b1;
        sub     = s;
        a       = x;
        b       = y;
        n       = 0;
        while (inReady !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("accept_timeout", 64'(n), 64'(0));
        @(posedge clk);
        #1 accept_cyc = cyc;
        @(negedge clk);
        inValid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (outValid !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int            lat;
        int            bad;
        int            first_cyc;
        logic          s;
        logic [W-1:0]  x;
        logic [W-1:0]  y;
        logic [W-1:0]  held;
        logic [W+3:0]  exp;

        checks   = 0;
        passes   = 0;
        fails    = 0;
        rstN     = 1'b1;
        inValid  = 1'b0;
        outReady = 1'b1;
        sub      = 1'b0;
        a        = '0;
        b        = '0;

        vecs[0] = '{1'b0, 32'd5,          32'd7,          {32'd12,         4'b0000}};
        vecs[1] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          {32'h0,          4'b1010}};
        vecs[2] = '{1'b0, 32'h7FFF_FFFF,  32'd1,          {32'h8000_0000,  4'b0101}};
        vecs[3] = '{1'b1, 32'd3,          32'd5,          {32'hFFFF_FFFE,  4'b0001}};
        vecs[4] = '{1'b1, 32'd5,          32'd5,          {32'h0,          4'b1010}};
        vecs[5] = '{1'b1, 32'h8000_0000,  32'd1,          {32'h7FFF_FFFF,  4'b1100}};
        vecs[6] = '{1'b1, 32'h1234_5678,  32'd0,          {32'h1234_5678,  4'b1000}};
        vecs[7] = '{1'b0, 32'd0,          32'd0,          {32'h0,          4'b0010}};

        // Asynchronous reset takes effect without a clock edge.
        #2 rstN = 1'b0;
        #1;
        check("reset_ctrl", 64'({inReady, outValid, cOut, overflow, zero, negative}), 64'(6'b100000));
        check("reset_result", 64'(result), 64'(0));
        repeat (2) @(negedge clk);
        rstN = 1'b1;

        // Directed table; the first op is offered on the first edge after reset release.
        for (int i = 0; i < 8; i++) begin
            start_op(vecs[i].s, vecs[i].x, vecs[i].y);
            wait_done(lat);
            $display("vec %0d sub=%0d a=%h b=%h result=%h c=%0d v=%0d z=%0d n=%0d lat=%0d",
                     i, vecs[i].s, vecs[i].x, vecs[i].y, result, cOut, overflow, zero, negative, lat);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(W));
            check($sformatf("vec%0d_result", i), 64'(dut_out()), 64'(vecs[i].exp));
            @(negedge clk);
            check($sformatf("vec%0d_pulse", i), 64'({outValid, inReady}), 64'(2'b01));
        end

        // Result and flags hold while idle.
        repeat (3) @(negedge clk);
        check("idle_hold", 64'(dut_out()), 64'(vecs[7].exp));

        // Reset pulse after ten RUN steps aborts the op.
        start_op(1'b0, 32'hFFFF_FFFF, 32'h0);
        repeat (10) @(posedge clk);
        #2 rstN = 1'b0;
        #1;
        check("midrun_reset_ctrl", 64'({outValid, inReady}), 64'(2'b01));
        check("midrun_reset_result", 64'(result), 64'(0));
        @(negedge clk);
        rstN = 1'b1;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (outValid !== 1'b0 || inReady !== 1'b1) bad++;
        end
        check("midrun_no_pulse", 64'(bad), 64'(0));
        start_op(1'b0, 32'h1234_5678, 32'h1111_1111);
        wait_done(lat);
        $display("post-reset op result=%h lat=%0d", result, lat);
        check("post_reset_latency", 64'(lat), 64'(W));
        check("post_reset_result", 64'(dut_out()), 64'({32'h2345_6789, 4'b0000}));

        // Backpressure with a queued op held on the input.
        @(negedge clk);
        outReady = 1'b0;
        start_op(1'b1, 32'd100, 32'd30);
        wait_done(lat);
        check("bp_result", 64'(dut_out()), 64'(model(1'b1, 32'd100, 32'd30)));
        held    = result;
        inValid = 1'b1;
        sub     = 1'b0;
        a       = 32'hAAAA_0000;
        b       = 32'h0000_BBBB;
        bad     = 0;
        repeat (10) begin
            @(negedge clk);
            if (outValid !== 1'b1 || result !== held || inReady !== 1'b0) bad++;
        end
        check("bp_hold", 64'(bad), 64'(0));
        outReady = 1'b1;
        @(negedge clk);
        check("bp_release", 64'({outValid, inReady}), 64'(2'b01));
        @(negedge clk);
        check("bp_queued_accept", 64'(inReady), 64'(0));
        inValid = 1'b0;
        wait_done(lat);
        $display("queued op result=%h lat=%0d", result, lat);
        check("bp_queued_latency", 64'(lat), 64'(W));
        check("bp_queued_result", 64'(dut_out()), 64'(model(1'b0, 32'hAAAA_0000, 32'h0000_BBBB)));

        // Randomized back-to-back traffic.
        first_cyc = 0;
        for (int i = 0; i < N_RAND; i++) begin
            s = 1'($urandom_range(0, 1));
            x = $urandom;
            case (i % 8)
                0: y = x;
                1: y = '0;
                2: y = 32'(x[3:0]);
                default: y = $urandom;
            endcase
            exp = model(s, x, y);
            start_op(s, x, y);
            if (i == 0) first_cyc = accept_cyc;
            wait_done(lat);
            $display("rand %0d sub=%0d a=%h b=%h result=%h c=%0d v=%0d z=%0d n=%0d lat=%0d",
                     i, s, x, y, result, cOut, overflow, zero, negative, lat);
            check($sformatf("rand%0d_latency", i), 64'(lat), 64'(W));
            check($sformatf("rand%0d_result", i), 64'(dut_out()), 64'(exp));
        end
        check("throughput", 64'(accept_cyc - first_cyc), 64'((N_RAND - 1) * (W + 2)));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
